// File: rtl/seg7_pkg.sv
// seg7_pkg: shared FSM state type, segment patterns and digit count for the 7-segment scanner
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam int NUM_DIGITS = 3;
endpackage

// File: rtl/seg7_digit_decode.sv
// seg7_digit_decode: combinational BCD digit to abcdefg segment pattern
//   digit_i  4-bit digit value; values above 9 decode to all-off
//   blank_i  forces all segments off
//   seg_o    segment pattern, abcdefg, active-high
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: binary-to-BCD converter feeding a 3-digit multiplexed 7-segment display
//   clk, rst_n   clock, asynchronous active-low reset
//   load_valid   load_data (0..255) is offered; taken when load_ready=1
//   load_ready   idle, a value can be accepted this cycle
//   blank_lz     blank leading-zero hundreds/tens digits
//   busy         conversion in progress
//   seg          registered segment drive, abcdefg, active-high
//   dig_en       registered one-hot digit enable, [0]=ones [1]=tens [2]=hundreds
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  input  logic       blank_lz,
  output logic       busy,
  output logic [6:0] seg,
  output logic [2:0] dig_en
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  state_t        state_q, state_d;
  logic [2:0]    iter_q, iter_d;
  logic [7:0]    bin_q, bin_d;
  logic [11:0]   bcd_q, bcd_d, bcd_adj;
  logic [11:0]   disp_q, disp_d;
  logic [DW-1:0] div_q;
  logic [1:0]    idx_q;
  logic [6:0]    seg_q, seg_dec;
  logic [2:0]    dig_en_q;
  logic [3:0]    cur_digit;
  logic          cur_blank, tc;
  assign load_ready = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: if (load_valid) begin
        state_d = CONV;
        iter_d  = 3'd0;
        bin_d   = load_data;
        bcd_d   = 12'd0;
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        iter_d         = iter_q + 3'd1;
        state_d        = iter_q == 3'd7 ? COMMIT : CONV;
      end
      COMMIT: begin
        disp_d  = bcd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      disp_q  <= disp_d;
    end
  end
  assign tc        = div_q == DW'(SCAN_DIV - 1);
  assign cur_digit = idx_q == 2'd2 ? disp_q[11:8] : idx_q == 2'd1 ? disp_q[7:4] : disp_q[3:0];
  // tens is only a leading zero when hundreds is zero too
  assign cur_blank = blank_lz && (idx_q == 2'd2 ? disp_q[11:8] == 4'd0 :
                                  idx_q == 2'd1 ? disp_q[11:4] == 8'd0 : 1'b0);
  seg7_digit_decode u_dec (
    .digit_i (cur_digit),
    .blank_i (cur_blank),
    .seg_o   (seg_dec)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_BLANK;
      dig_en_q <= '0;
    end else begin
      div_q    <= tc ? '0 : div_q + DW'(1);
      idx_q    <= tc ? (idx_q == 2'(NUM_DIGITS - 1) ? 2'd0 : idx_q + 2'd1) : idx_q;
      seg_q    <= seg_dec;
      dig_en_q <= 3'b001 << idx_q;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: table-driven and sequence checks of the 7-segment scan controller
module tb_seg7_scan_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, load_valid = 1'b0, blank_lz = 1'b0;
  logic [7:0] load_data = 8'd0;
  logic       load_ready, busy, ready1, busy1;
  logic [6:0] seg, seg1;
  logic [2:0] dig_en, dig_en1;
  logic [6:0] cap [3];
  int errors = 0, checks = 0;
  typedef struct {
    bit         ld;
    logic [7:0] v;
    logic       bl;
    logic [6:0] o, t, h;
  } vec_t;
  vec_t tbl [10];
  always #5 clk = ~clk;
  seg7_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .blank_lz(blank_lz), .busy(busy), .seg(seg), .dig_en(dig_en)
  );
  seg7_scan_ctrl #(.SCAN_DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(ready1), .blank_lz(blank_lz), .busy(busy1), .seg(seg1), .dig_en(dig_en1)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic logic [6:0] dec(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction
  function automatic logic [6:0] exp_seg(input int v, input logic [2:0] en);
    return dec(en == 3'b001 ? v % 10 : en == 3'b010 ? (v / 10) % 10 : v / 100);
  endfunction
  task automatic wait_ready(output int n);
    n = 0;
    while (!load_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!load_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: load_ready still %0b after %0d cycles", load_ready, n);
    end
  endtask
  task automatic do_load(input logic [7:0] v, input string name);
    int n, c;
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = v;
    wait_ready(n);
    @(negedge clk);
    load_valid = 1'b0;
    c = 0;
    while (busy && c < 40) begin
      c++;
      @(negedge clk);
    end
    chk({name, " busy_cycles"}, c, 9);
  endtask
  task automatic capture();
    cap[0] = 'x;
    cap[1] = 'x;
    cap[2] = 'x;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i > 0)
        case (dig_en)
          3'b001:  cap[0] = seg;
          3'b010:  cap[1] = seg;
          3'b100:  cap[2] = seg;
          default: ;
        endcase
    end
  endtask
  task automatic wait_dig(input logic [2:0] v);
    int c = 0;
    while (dig_en == v && c < 50) begin @(negedge clk); c++; end
    while (dig_en != v && c < 50) begin @(negedge clk); c++; end
    if (c >= 50) begin
      checks++;
      errors++;
      $display("FAIL wait_dig: dig_en %b never reached %b", dig_en, v);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end
  initial begin
    int n, c;
    int vals [3];
    tbl[0] = '{1'b1, 8'd0,   1'b0, 7'b1111110, 7'b1111110, 7'b1111110};
    tbl[1] = '{1'b1, 8'd255, 1'b0, 7'b1011011, 7'b1011011, 7'b1101101};
    tbl[2] = '{1'b1, 8'd7,   1'b1, 7'b1110000, 7'b0000000, 7'b0000000};
    tbl[3] = '{1'b0, 8'd0,   1'b0, 7'b1110000, 7'b1111110, 7'b1111110};
    tbl[4] = '{1'b1, 8'd42,  1'b1, 7'b1101101, 7'b0110011, 7'b0000000};
    tbl[5] = '{1'b1, 8'd109, 1'b1, 7'b1111011, 7'b1111110, 7'b0110000};
    tbl[6] = '{1'b1, 8'd80,  1'b1, 7'b1111110, 7'b1111111, 7'b0000000};
    tbl[7] = '{1'b1, 8'd138, 1'b0, 7'b1111111, 7'b1111001, 7'b0110000};
    tbl[8] = '{1'b1, 8'd156, 1'b0, 7'b1011111, 7'b1011011, 7'b0110000};
    tbl[9] = '{1'b1, 8'd0,   1'b1, 7'b1111110, 7'b0000000, 7'b0000000};
    repeat (2) @(negedge clk);
    chk("rst seg", seg, 7'b0000000);
    chk("rst dig_en", dig_en, 3'b000);
    chk("rst load_ready", load_ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst dig_en", dig_en, 3'b001);
    chk("post_rst seg", seg, 7'b1111110);
    chk("div1 dig_en0", dig_en1, 3'b001);
    @(negedge clk);
    chk("div1 dig_en1", dig_en1, 3'b010);
    @(negedge clk);
    chk("div1 dig_en2", dig_en1, 3'b100);
    @(negedge clk);
    chk("div1 dig_en3", dig_en1, 3'b001);
    wait_dig(3'b001);
    c = 0;
    while (dig_en == 3'b001 && c < 20) begin @(negedge clk); c++; end
    chk("dig_en hold", c, 4);
    for (int i = 0; i < 10; i++) begin
      blank_lz = tbl[i].bl;
      if (tbl[i].ld) do_load(tbl[i].v, $sformatf("vec%0d", i));
      else @(negedge clk);
      capture();
      chk($sformatf("vec%0d ones", i), cap[0], tbl[i].o);
      chk($sformatf("vec%0d tens", i), cap[1], tbl[i].t);
      chk($sformatf("vec%0d hund", i), cap[2], tbl[i].h);
    end
    blank_lz = 1'b1;
    do_load(8'd7, "blank7");
    wait_dig(3'b100);
    chk("blank hund on", seg, 7'b0000000);
    blank_lz = 1'b0;
    @(negedge clk);
    chk("blank toggle dig_en", dig_en, 3'b100);
    chk("blank toggle seg", seg, 7'b1111110);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 8'd42;
    wait_ready(n);
    @(negedge clk);
    load_data = 8'd99;
    wait_ready(n);
    chk("hold99 gap", n, 9);
    @(negedge clk);
    load_valid = 1'b0;
    chk("hold99 accepted", busy, 1'b1);
    chk("hold99 shows 42", seg, exp_seg(42, dig_en));
    wait_ready(n);
    capture();
    chk("show99 ones", cap[0], 7'b1111011);
    chk("show99 tens", cap[1], 7'b1111011);
    chk("show99 hund", cap[2], 7'b1111110);
    vals = '{0, 100, 199};
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 8'(vals[0]);
    for (int k = 0; k < 3; k++) begin
      wait_ready(n);
      if (k > 0) chk($sformatf("stream gap%0d", k), n, 8);
      @(negedge clk);
      if (k < 2) load_data = 8'(vals[k + 1]);
      else load_valid = 1'b0;
      @(negedge clk);
      if (k > 0) chk($sformatf("stream show%0d", k - 1), seg, exp_seg(vals[k - 1], dig_en));
    end
    wait_ready(n);
    chk("stream gap_last", n, 8);
    @(negedge clk);
    chk("stream show2", seg, exp_seg(vals[2], dig_en));
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 8'd200;
    wait_ready(n);
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort seg", seg, 7'b0000000);
    chk("abort dig_en", dig_en, 3'b000);
    chk("abort load_ready", load_ready, 1'b1);
    chk("abort busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort restart idx", dig_en, 3'b001);
    capture();
    chk("abort ones", cap[0], 7'b1111110);
    chk("abort tens", cap[1], 7'b1111110);
    chk("abort hund", cap[2], 7'b1111110);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each digit stays enabled; legal range >= 1.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 load_valid  input  1  load_data holds a new 8-bit binary value to display.
REQ-005 load_data  input  8  unsigned binary value, 0..255.
REQ-006 load_ready  output  1  block can accept a value this cycle.
REQ-007 blank_lz  input  1  1 = blank leading-zero digits.
REQ-008 busy  output  1  conversion in progress.
REQ-009 seg  output  7  segment drive, order abcdefg, active-high, registered.
REQ-010 dig_en  output  3  one-hot digit enable, [0]=ones, [1]=tens, [2]=hundreds, active-high, registered.

Function
REQ-011 The block SHALL use an FSM with states IDLE, CONV and COMMIT.
REQ-012 load_ready SHALL be 1 exactly when state is IDLE; busy SHALL be 1 exactly when state is not IDLE.
REQ-013 Handshake: a load SHALL occur on an edge where load_valid=1 and load_ready=1; load_data SHALL be captured on that edge, and state SHALL become CONV with an iteration count of 0.
REQ-014 load_valid SHALL be ignored while load_ready=0; data is not queued.
REQ-015 CONV SHALL perform one shift-add-3 (double-dabble) iteration per clock, MSB first, on a 12-bit BCD accumulator; 8 iterations SHALL complete on edges T+1..T+8 after accept edge T.
REQ-016 Each iteration SHALL add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one.
REQ-017 On edge T+8, state SHALL go to COMMIT; on edge T+9, the three display digit registers SHALL load the result and state SHALL return to IDLE.
REQ-018 The maximum accepted load rate SHALL be one per 10 cycles; the display registers SHALL hold the previous value until the commit edge.
REQ-019 Prescaler: a counter SHALL count 0..SCAN_DIV-1 and wrap; at terminal count, the digit index SHALL advance 0->1->2->0. With SCAN_DIV=1, the index SHALL advance every cycle.
REQ-020 The prescaler and digit index SHALL run continuously, independent of FSM state.
REQ-021 Every cycle, dig_en SHALL register the one-hot of the current index, and seg SHALL register the decoded pattern of the selected digit (1-cycle output latency).
REQ-022 Decode: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; any other value SHALL decode to 0000000.
REQ-023 When blank_lz=1, the hundreds digit SHALL show 0000000 if it is 0, and the tens digit SHALL show 0000000 if both hundreds and tens are 0; the ones digit SHALL never be blanked.
REQ-024 A blanked digit SHALL still receive its dig_en slot.
REQ-025 blank_lz SHALL take effect without a reload; it is sampled in the same cycle as the seg register update.

Reset
REQ-026 While rst_n=0, the block SHALL hold: state IDLE, iteration count 0, accumulator 0, display digits 000, prescaler 0, index 0, seg=0000000, dig_en=000, load_ready=1, busy=0.
REQ-027 Reset asserted mid-CONV or mid-COMMIT SHALL abort the conversion with no commit.
REQ-028 After rst_n is released, scanning SHALL restart at index 0.

Structure
REQ-029 Package seg7_pkg SHALL hold the FSM state enum, the ten segment constants, SEG_BLANK, and the digit-count constant (3).
REQ-030 Sub-module seg7_digit_decode SHALL hold the combinational 4-bit to 7-segment decode, with a blank input; all sequencing SHALL remain in seg7_scan_ctrl.

Verification
REQ-031 Reset check: during and after reset -> seg=0000000, dig_en=000, load_ready=1, busy=0; one cycle after release, dig_en=001 with seg=1111110.
REQ-032 Load 255, SCAN_DIV=4 -> busy=1 for 9 cycles; then the cycling dig_en shows 001/1011011, 010/1011011, 100/1101101, each held 4 cycles.
REQ-033 Load 7 -> with blank_lz=1, hundreds and tens show 0000000 and ones shows 1110000; switching blank_lz to 0 -> hundreds and tens show 1111110 within 1 cycle.
REQ-034 Load 42, then hold load_valid with 99 during busy -> 99 is not taken until load_ready=1; the display reads 042 for at least one cycle, then 099 about 10 cycles later.
REQ-035 Load 200 and assert rst_n at iteration 4 -> all outputs at reset values; after release, the display shows 000.
REQ-036 load_valid held high with 0, 100, 199 -> accepts are exactly 10 cycles apart; the display shows 000, 100, 199 in order.
